// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family.
// Holds the default geometry, an elaboration-time log2 and the even-parity reduction.
package fifo_pkg;

  localparam int DEF_D_WIDTH = 8;
  localparam int DEF_D_DEPTH = 16;
  localparam int PAR_MAX_W   = 256;

  function automatic int fifo_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Zero-extension leaves the XOR reduction unchanged, so callers cast up to PAR_MAX_W.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-facing bundle of sync_fifo_param; master drives requests, slave is the FIFO.
// parity_err exists only when FIFO_PARITY_EN is defined.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int D_ADDR  = 4
);

  logic               flush;
  logic               write;
  logic               read;
  logic [D_WIDTH-1:0] d_in;
  logic [D_WIDTH-1:0] d_out;
  logic               empty;
  logic               full;
  logic               almost_empty;
  logic               almost_full;
  logic [D_ADDR:0]    count;
  logic               overflow;
  logic               underflow;
`ifdef FIFO_PARITY_EN
  logic               parity_err;
`endif

  modport master (
    output flush, write, read, d_in,
    input  d_out, empty, full, almost_empty, almost_full, count, overflow, underflow
`ifdef FIFO_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  flush, write, read, d_in,
    output d_out, empty, full, almost_empty, almost_full, count, overflow, underflow
`ifdef FIFO_PARITY_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// Register-array storage: one synchronous write port, one registered read port with enable.
// Read data appears the cycle after re; clr and reset zero the read register, never the array.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_D_WIDTH,
  parameter int DEPTH = DEF_D_DEPTH,
  parameter int ADDR  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we,
  input  logic [ADDR-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [ADDR-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (clr)     rdata_d = '0;
    else if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised same-clock FIFO: d_out valid 1 cycle after an accepted read; full drops writes (overflow), empty refuses reads (underflow).
// Optional parity storage/check under FIFO_PARITY_EN; occupancy tracked by count, flags decoded from it.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int D_WIDTH   = DEF_D_WIDTH,
  parameter int D_DEPTH   = DEF_D_DEPTH,
  parameter int D_ADDR    = 4,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_param_if.slave fif
);

  if (D_DEPTH < 4 || D_ADDR != fifo_log2(D_DEPTH) || (1 << D_ADDR) != D_DEPTH) begin : g_bad_cfg
    $error("sync_fifo_param: D_DEPTH must be a power of two >= 4 with D_ADDR = log2(D_DEPTH)");
  end

`ifdef FIFO_PARITY_EN
  localparam int MEM_W = D_WIDTH + 1;
`else
  localparam int MEM_W = D_WIDTH;
`endif

  localparam logic [D_ADDR-1:0] PTR_ONE  = {{(D_ADDR-1){1'b0}}, 1'b1};
  localparam logic [D_ADDR:0]   CNT_ONE  = {{D_ADDR{1'b0}}, 1'b1};
  localparam logic [D_ADDR:0]   CNT_FULL = (D_ADDR+1)'(D_DEPTH);
  localparam logic [D_ADDR:0]   CNT_AF   = (D_ADDR+1)'(AF_THRESH);
  localparam logic [D_ADDR:0]   CNT_AE   = (D_ADDR+1)'(AE_THRESH);

  logic [D_ADDR-1:0] wr_pntr_q, wr_pntr_d, rd_pntr_q, rd_pntr_d;
  logic [D_ADDR:0]   count_q, count_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              full_w, empty_w, wr_ok, rd_ok;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata;

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // Flush outranks both requests; empty never bypasses a same-cycle write to the reader.
  always_comb begin
    wr_ok       = 1'b0;
    rd_ok       = 1'b0;
    wr_pntr_d   = wr_pntr_q;
    rd_pntr_d   = rd_pntr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (fif.flush) begin
      wr_pntr_d = '0;
      rd_pntr_d = '0;
      count_d   = '0;
    end else begin
      wr_ok       = fif.write & (~full_w | fif.read);
      rd_ok       = fif.read & ~empty_w;
      overflow_d  = fif.write & full_w & ~fif.read;
      underflow_d = fif.read & empty_w & ~fif.write;
      if (wr_ok) wr_pntr_d = wr_pntr_q + PTR_ONE;
      if (rd_ok) rd_pntr_d = rd_pntr_q + PTR_ONE;
      if (wr_ok & ~rd_ok)      count_d = count_q + CNT_ONE;
      else if (rd_ok & ~wr_ok) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_pntr_q   <= '0;
      rd_pntr_q   <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_pntr_q   <= wr_pntr_d;
      rd_pntr_q   <= rd_pntr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_PARITY_EN
  logic rd_vld_q, rd_vld_d;

  assign mem_wdata = {even_par(PAR_MAX_W'(fif.d_in)), fif.d_in};
  assign rd_vld_d  = rd_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_vld_q <= 1'b0;
    else       rd_vld_q <= rd_vld_d;
  end

  // A stored word plus its parity bit must XOR to zero; only the freshly read word is judged.
  assign fif.parity_err = rd_vld_q & even_par(PAR_MAX_W'(mem_rdata));
`else
  assign mem_wdata = fif.d_in;
`endif

  fifo_mem_dp #(
    .WIDTH (MEM_W),
    .DEPTH (D_DEPTH),
    .ADDR  (D_ADDR)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .clr   (fif.flush),
    .we    (wr_ok),
    .waddr (wr_pntr_q),
    .wdata (mem_wdata),
    .re    (rd_ok),
    .raddr (rd_pntr_q),
    .rdata (mem_rdata)
  );

  assign fif.d_out        = mem_rdata[D_WIDTH-1:0];
  assign fif.empty        = empty_w;
  assign fif.full         = full_w;
  assign fif.almost_empty = (count_q <= CNT_AE);
  assign fif.almost_full  = (count_q >= CNT_AF);
  assign fif.count        = count_q;
  assign fif.overflow     = overflow_q;
  assign fif.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: queue-based reference checked every cycle, plus directed literal checks.
// Parity injection section is active only when FIFO_PARITY_EN is defined.
module tb_sync_fifo_param;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic chk_on   = 1'b0;

  sync_fifo_param_if #(.D_WIDTH(W), .D_ADDR(AW)) fif ();

  sync_fifo_param #(
    .D_WIDTH   (W),
    .D_DEPTH   (DEPTH),
    .D_ADDR    (AW),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of stored words and the last word handed out.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = '0;
  logic         m_ov   = 1'b0;
  logic         m_un   = 1'b0;

  always @(posedge clk or posedge reset) begin
    int n;
    if (reset || fif.flush) begin
      q.delete();
      m_dout = '0;
      m_ov   = 1'b0;
      m_un   = 1'b0;
    end else begin
      n    = q.size();
      m_ov = fif.write && (n == DEPTH) && !fif.read;
      m_un = fif.read && (n == 0) && !fif.write;
      if (fif.read && n > 0) m_dout = q.pop_front();
      if (fif.write && (n < DEPTH || fif.read)) q.push_back(fif.d_in);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_count", 32'(fif.count), 32'(q.size()));
      chk("cyc_empty", 32'(fif.empty), 32'(q.size() == 0));
      chk("cyc_full", 32'(fif.full), 32'(q.size() == DEPTH));
      chk("cyc_almost_empty", 32'(fif.almost_empty), 32'(q.size() <= AE));
      chk("cyc_almost_full", 32'(fif.almost_full), 32'(q.size() >= AF));
      chk("cyc_d_out", 32'(fif.d_out), 32'(m_dout));
      chk("cyc_overflow", 32'(fif.overflow), 32'(m_ov));
      chk("cyc_underflow", 32'(fif.underflow), 32'(m_un));
    end
  end

  task automatic cyc(input logic w, input logic r, input logic f, input logic [W-1:0] d);
    fif.write = w;
    fif.read  = r;
    fif.flush = f;
    fif.d_in  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] held;
    fif.write = 1'b0;
    fif.read  = 1'b0;
    fif.flush = 1'b0;
    fif.d_in  = '0;
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_count", 32'(fif.count), 0);
    chk("reset_empty", 32'(fif.empty), 1);
    reset  = 1'b0;
    chk_on = 1'b1;
    cyc(0, 0, 0, 0);
    chk("idle_empty", 32'(fif.empty), 1);
    chk("idle_almost_empty", 32'(fif.almost_empty), 1);
    chk("idle_count", 32'(fif.count), 0);
    chk("idle_d_out", 32'(fif.d_out), 0);
    chk("idle_full", 32'(fif.full), 0);

    // Fill with 10*i, then one write too many.
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 0, W'(10 * i));
      chk("fill_almost_full", 32'(fif.almost_full), 32'(i >= 13));
    end
    chk("fill_count", 32'(fif.count), 16);
    chk("fill_full", 32'(fif.full), 1);
    chk("model_fill_size", 32'(q.size()), 16);
    cyc(1, 0, 0, 8'd99);
    chk("ovf_pulse", 32'(fif.overflow), 1);
    chk("ovf_count", 32'(fif.count), 16);
    cyc(0, 0, 0, 0);
    chk("ovf_cleared", 32'(fif.overflow), 0);

    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 0);
      chk("drain_d_out", 32'(fif.d_out), 32'(10 * i));
    end
    chk("drain_empty", 32'(fif.empty), 1);
    cyc(0, 1, 0, 0);
    chk("udf_pulse", 32'(fif.underflow), 1);
    chk("udf_d_out", 32'(fif.d_out), 150);
    cyc(0, 0, 0, 0);
    chk("udf_cleared", 32'(fif.underflow), 0);

    // Full with simultaneous read+write: pass-through at constant occupancy.
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, W'(10 * i));
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 8'd222);
      chk("rw_full_count", 32'(fif.count), 16);
      chk("rw_full_no_ovf", 32'(fif.overflow), 0);
      chk("rw_full_d_out", 32'(fif.d_out), 32'(10 * i));
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 0);
      chk("wrap_d_out", 32'(fif.d_out), (i < 12) ? 32'(10 * (i + 4)) : 32'd222);
    end

    // Empty with simultaneous read+write: write only, no bypass.
    cyc(0, 0, 0, 0);
    held = fif.d_out;
    cyc(1, 1, 0, 8'd77);
    chk("rw_empty_count", 32'(fif.count), 1);
    chk("rw_empty_d_out", 32'(fif.d_out), 32'(held));
    chk("rw_empty_no_udf", 32'(fif.underflow), 0);
    cyc(0, 1, 0, 0);
    chk("rw_empty_read", 32'(fif.d_out), 77);

    // Flush beats a same-cycle read and write.
    for (int i = 1; i <= 5; i++) cyc(1, 0, 0, W'(i));
    cyc(0, 1, 0, 0);
    chk("pre_flush_d_out", 32'(fif.d_out), 1);
    cyc(1, 1, 1, 8'd55);
    chk("flush_count", 32'(fif.count), 0);
    chk("flush_empty", 32'(fif.empty), 1);
    chk("flush_d_out", 32'(fif.d_out), 0);
    chk("model_flush_size", 32'(q.size()), 0);

`ifdef FIFO_PARITY_EN
    cyc(1, 0, 0, 8'h01);
    cyc(1, 0, 0, 8'h03);
    cyc(1, 0, 0, 8'h07);
    cyc(0, 0, 0, 0);
    dut.u_mem.mem_q[1][W] = ~dut.u_mem.mem_q[1][W];
    cyc(0, 1, 0, 0);
    chk("par_good0", 32'(fif.parity_err), 0);
    cyc(0, 1, 0, 0);
    chk("par_bad", 32'(fif.parity_err), 1);
    chk("par_bad_d_out", 32'(fif.d_out), 3);
    cyc(0, 1, 0, 0);
    chk("par_good2", 32'(fif.parity_err), 0);
    cyc(0, 0, 0, 0);
    chk("par_idle", 32'(fif.parity_err), 0);
`endif

    // Random traffic in phases alternating fill-biased and drain-biased.
    for (int c = 0; c < 3000; c++) begin
      int wp;
      wp    = ((c / 300) % 2 == 0) ? 70 : 30;
      reset = ($urandom_range(399) == 0);
      cyc($urandom_range(99) < wp, $urandom_range(99) < (100 - wp),
          $urandom_range(99) == 0, W'($urandom));
    end
    reset = 1'b0;
    cyc(0, 0, 0, 0);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO; successor to the fixed 16x8 FIFO.
- Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, overflow/underflow pulses, a synchronous flush, and an optional parity check.
- Sits between a producer and a consumer in the same clock domain and is the team's standard buffering element.

Parameters:
- D_WIDTH, 8: data word width in bits (>=1).
- D_DEPTH, 16: number of entries; must be a power of two and >=4.
- D_ADDR, 4: pointer width; must equal log2(D_DEPTH).
- AF_THRESH, 14: almost_full asserts when count >= AF_THRESH (1..D_DEPTH).
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH (0..D_DEPTH-1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents.
- d_in  in  D_WIDTH  write data.
- write  in  1  write request.
- read  in  1  read request.
- d_out  out  D_WIDTH  read data, registered.
- empty  out  1  count == 0.
- full  out  1  count == D_DEPTH.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  D_ADDR+1  current occupancy, 0..D_DEPTH.
- overflow  out  1  one-cycle pulse: write dropped.
- underflow  out  1  one-cycle pulse: read refused.
- parity_err  out  1  present only with FIFO_PARITY_EN; see Optional Feature.

Behaviour:
- Reset (asynchronous, while reset=1):
  - wr_pntr, rd_pntr, count = 0; d_out = 0.
  - empty = 1, almost_empty = 1; full = 0, almost_full = 0.
  - overflow = 0, underflow = 0, parity_err = 0.
  - Memory contents are not cleared.
  - Reset mid-operation aborts any transfer in that cycle.
- Priority: reset > flush > read/write.
- Flush:
  - Next edge: pointers = 0, count = 0, d_out = 0, overflow and underflow = 0.
  - read and write are ignored in the flush cycle.
- Accepted write (wr_ok) = write & (~full | read).
  - Stores d_in at mem[wr_pntr]; wr_pntr increments modulo D_DEPTH.
- Accepted read (rd_ok) = read & ~empty.
  - d_out <= mem[rd_pntr] on the same edge, so data is valid 1 cycle after read is sampled.
  - rd_pntr increments modulo D_DEPTH.
  - d_out holds its value when no read is accepted.
- Count update per edge:
  - +1 when wr_ok & ~rd_ok.
  - -1 when rd_ok & ~wr_ok.
  - Unchanged otherwise.
- Simultaneous read and write:
  - When full: both are accepted and count stays at D_DEPTH.
  - When empty: only the write is accepted (no bypass), d_out is unchanged, and count becomes 1.
- overflow = 1 for exactly the cycle after write & full & ~read; the d_in word is dropped.
- underflow = 1 for exactly the cycle after read & empty; d_out is unchanged.
- Flags are decoded combinationally from the count register, so they change in the same cycle as count. No look-ahead.
- Pointer wrap is natural binary rollover from D_DEPTH-1 to 0; full and empty are resolved by count, not by pointer compare.

Optional Feature:
- Macro: FIFO_PARITY_EN.
- Defined:
  - Each memory entry is D_WIDTH+1 bits and stores the even parity of d_in.
  - On an accepted read, the stored parity is recomputed and checked.
  - parity_err is registered alongside d_out; it is 1 for one cycle when the check fails and 0 otherwise.
  - flush and reset clear parity_err.
- Undefined: the memory is D_WIDTH bits wide, and the parity_err port and its logic are absent.

Decomposition:
- Shared package fifo_pkg holds:
  - default constants: DEF_D_WIDTH = 8, DEF_D_DEPTH = 16;
  - an elaboration-time log2 function used to check D_ADDR;
  - a parity function.
- One sub-module, fifo_mem_dp:
  - D_DEPTH x (D_WIDTH or D_WIDTH+1) register array;
  - one synchronous write port and one registered read port with read enable.
- Pointers, count, flags, and the error pulses stay in sync_fifo_param.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, count=0, d_out=0, full=0.
- Write 10*i for i=0..15 -> count reaches 16, full=1; almost_full first asserts after the 14th write; a 17th write -> overflow pulses 1 cycle, count stays 16.
- Then read 16 times -> d_out = 0,10,...,150, each 1 cycle after its read; empty=1 after the last; one extra read -> underflow pulses, d_out stays 150.
- Fill to 16, then read+write of 222 together for 4 cycles -> count stays 16, no overflow; subsequent drain shows the wrapped order ending with four 222s.
- Empty FIFO with read+write of 77 -> count=1, d_out unchanged, no underflow; read next cycle -> d_out=77.
- With 5 words stored, assert flush -> count=0, empty=1, d_out=0; with FIFO_PARITY_EN, force a stored parity bit flip -> parity_err=1 on that read only.
